// File: rtl/sram_responder.sv
// Word-addressed SRAM slave for a fixed byte-address window. An optional zero-fill
// sweep runs after every reset before accesses are served.
module sram_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h1c000000,
  parameter int          DEPTH_LOG2 = 14,
  parameter bit          INIT_ZERO  = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        init_busy,
  output logic        addr_err,
  output logic [15:0] wr_count
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DEPTH_LOG2-1:0] r_sweep;
  logic [DEPTH_LOG2-1:0] w_sweep_nxt;
  logic                  w_sweep_we;
  logic [31:0]           r_rdata;
  logic                  r_addr_err;
  logic [15:0]           r_wr_count;
  logic [31:0]           r_mem [WORDS];

  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_inwin;
  logic                  w_ready;
  logic                  w_wr_ok;
  logic                  w_wr_bad;
  logic                  w_unused;

  assign w_idx    = sram_addr[DEPTH_LOG2+1:2];
  assign w_inwin  = (sram_addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
  assign w_ready  = (r_state == READY);
  assign w_wr_ok  = w_ready && sram_we && w_inwin;
  assign w_wr_bad = w_ready && sram_we && !w_inwin;
  // Byte-lane bits carry no meaning for a word-only store.
  assign w_unused = ^sram_addr[1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep;
    w_sweep_we  = 1'b0;
    case (r_state)
      INIT: begin
        if (INIT_ZERO) begin
          w_sweep_we  = 1'b1;
          w_sweep_nxt = r_sweep + DEPTH_LOG2'(1);
          if (&r_sweep) w_state_nxt = READY;
        end else begin
          w_state_nxt = READY;
        end
      end
      READY: begin
        w_state_nxt = READY;
      end
      default: begin
        w_state_nxt = INIT;
      end
    endcase
  end

  // Reset parks the FSM in INIT so init_busy reads high throughout reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= INIT;
      r_sweep    <= '0;
      r_rdata    <= 32'h0;
      r_addr_err <= 1'b0;
      r_wr_count <= 16'h0;
    end else begin
      r_state <= w_state_nxt;
      r_sweep <= w_sweep_nxt;
      if (w_ready && w_inwin) begin
        r_rdata <= sram_we ? sram_wdata : r_mem[w_idx];
      end else begin
        r_rdata <= 32'h0;
      end
      if (w_wr_ok)  r_wr_count <= r_wr_count + 16'd1;
      if (w_wr_bad) r_addr_err <= 1'b1;
    end
  end

  // Storage has no reset; only the sweep or accepted writes change it.
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (w_sweep_we) begin
        r_mem[r_sweep] <= 32'h0;
      end else if (w_wr_ok) begin
        r_mem[w_idx] <= sram_wdata;
      end
    end
  end

  assign sram_rdata = r_rdata;
  assign init_busy  = (r_state == INIT);
  assign addr_err   = r_addr_err;
  assign wr_count   = r_wr_count;

endmodule
